act_throttle_queue: RTL and testbench
=====================================

ACT_THROTTLE_QUEUE -- requirements
Module: act_throttle_queue

Interface
REQ-001 SHALL have parameter ROW_W, default 16: row address width.
REQ-002 SHALL have parameter CORE_W, default 3: core ID width.
REQ-003 SHALL have parameter DEPTH, default 4: pending-ACT FIFO entries, power of two.
REQ-004 SHALL have parameter T_DELAY, default 32: throttle wait in cycles, at least 1.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have ports req_valid (input, 1), req_ready (output, 1), req_row (input, ROW_W), req_core (input, CORE_W): ACT request from the scheduler.
REQ-008 SHALL have ports bh_row_addr (output, ROW_W), bh_core_id (output, CORE_W), bh_in_valid (output, 1): query and insert toward the blockhammer block.
REQ-009 SHALL have port bh_is_safe, input, 1: blockhammer verdict, combinational on bh_row_addr and bh_core_id.
REQ-010 SHALL have ports act_valid (output, 1), act_ready (input, 1), act_row (output, ROW_W), act_core (output, CORE_W): ACT issue toward the DRAM command bus.
REQ-011 SHALL have port busy, output, 1: state not IDLE or FIFO non-empty.
REQ-012 SHALL have port throttle_cnt, output, 16: saturating count of unsafe verdicts.

Function
REQ-013 SHALL accept a request on a cycle where req_valid and req_ready are both 1, writing {req_row, req_core} at the FIFO tail.
REQ-014 SHALL drive req_ready = (count < DEPTH), independent of req_valid; when full, SHALL NOT bypass, even with a simultaneous pop.
REQ-015 SHALL handle a simultaneous push and pop so that count is unchanged and FIFO order is preserved; pointers wrap modulo DEPTH.
REQ-016 SHALL drive bh_row_addr, bh_core_id, act_row and act_core from the FIFO head entry when non-empty, and 0 when empty.
REQ-017 SHALL implement FSM states IDLE, CHECK, WAIT and ISSUE.
REQ-018 In IDLE, SHALL go to CHECK on the next cycle if count != 0, else stay in IDLE.
REQ-019 In CHECK, SHALL sample bh_is_safe in that cycle: 1 goes to ISSUE; 0 goes to WAIT with delay counter = T_DELAY-1 and throttle_cnt incremented, saturating at 0xFFFF.
REQ-020 In WAIT, SHALL decrement the delay counter each cycle and go to CHECK the cycle after the counter reads 0, i.e. exactly T_DELAY cycles in WAIT.
REQ-021 In ISSUE, SHALL hold act_valid = 1 with act_row and act_core stable until act_ready = 1.
REQ-022 On the act_valid and act_ready handshake cycle, SHALL assert bh_in_valid for exactly that one cycle and pop the head.
REQ-023 After the handshake, SHALL go to CHECK if entries remain after the pop, else to IDLE.
REQ-024 SHALL keep bh_in_valid = 0 in all other cycles; a query is never an insertion.
REQ-025 SHALL keep act_valid = 0 outside ISSUE.
REQ-026 SHALL serve requests strictly in order; an unsafe head blocks all younger entries (head-of-line).
REQ-027 SHALL have a latency of 2 cycles: accept at cycle 0 into an empty idle block, CHECK at cycle 1, act_valid at cycle 2.
REQ-028 SHALL add T_DELAY+1 cycles of latency per unsafe verdict.
REQ-029 SHALL keep accepting requests during WAIT and ISSUE while not full.

Reset
REQ-030 While rst = 1, SHALL force state IDLE, FIFO empty, pointers 0, delay counter 0, throttle_cnt 0.
REQ-031 While rst = 1, SHALL force outputs act_valid 0, bh_in_valid 0, busy 0, req_ready 1, and all data outputs 0.
REQ-032 SHALL treat reset mid-operation (any state) as discarding all pending entries, with no ACT issued for them after release.

Verification
REQ-033 SHALL pass this test: T_DELAY 32, safe=1, act_ready=1, push row 0x1234 core 2 at cycle 0 -> act_valid and bh_in_valid at cycle 2 with act_row 0x1234, act_core 2; idle at cycle 3; throttle_cnt 0.
REQ-034 SHALL pass this test: same, with bh_is_safe=0 at the first CHECK and 1 after -> WAIT cycles 2..33, CHECK at 34, act_valid at 35; throttle_cnt 1.
REQ-035 SHALL pass this test: act_ready=0 for 10 cycles in ISSUE -> act_valid held, act_row stable, bh_in_valid 0; single bh_in_valid pulse on the handshake cycle.
REQ-036 SHALL pass this test: act_ready=0, push rows 1,2,3,4 -> req_ready 0 after the 4th; a 5th req_valid is not accepted; after release, ACTs come out in order 1,2,3,4 with 4 bh_in_valid pulses.
REQ-037 SHALL pass this test: head unsafe, then a younger safe entry pushed -> no act for the younger entry before the head issues.
REQ-038 SHALL pass this test: rst pulsed in cycle 10 of WAIT with 3 entries pending -> all outputs at reset values; no act_valid after release until new requests arrive.

Source files
------------

// File: rtl/act_throttle_queue.sv
// In-order ACT queue that asks blockhammer whether the head row is safe, throttles
// unsafe heads for T_DELAY cycles, and inserts each issued ACT into blockhammer.
module act_throttle_queue #(
  parameter int ROW_W   = 16,
  parameter int CORE_W  = 3,
  parameter int DEPTH   = 4,
  parameter int T_DELAY = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ROW_W-1:0]  req_row,
  input  logic [CORE_W-1:0] req_core,
  output logic [ROW_W-1:0]  bh_row_addr,
  output logic [CORE_W-1:0] bh_core_id,
  output logic              bh_in_valid,
  input  logic              bh_is_safe,
  output logic              act_valid,
  input  logic              act_ready,
  output logic [ROW_W-1:0]  act_row,
  output logic [CORE_W-1:0] act_core,
  output logic              busy,
  output logic [15:0]       throttle_cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = (T_DELAY > 1) ? $clog2(T_DELAY) : 1;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [CORE_W-1:0] core;
  } ent_t;

  typedef enum logic [1:0] {IDLE, CHECK, WAIT, ISSUE} state_t;

  ent_t          mem [DEPTH];
  ent_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [DW-1:0] dly;
  state_t        state;
  logic          push, pop;

  assign req_ready = count < CW'(DEPTH);
  assign push      = req_valid & req_ready;
  assign act_valid = (state == ISSUE);
  assign pop       = act_valid & act_ready;
  assign count_nxt = count + CW'(push) - CW'(pop);

  // Head is zeroed when empty so the query/issue buses never show stale rows.
  assign head        = (count != '0) ? mem[rd_ptr] : '0;
  assign bh_row_addr = head.row;
  assign bh_core_id  = head.core;
  assign act_row     = head.row;
  assign act_core    = head.core;
  assign bh_in_valid = pop;
  assign busy        = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{row: req_row, core: req_core};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      dly          <= '0;
      throttle_cnt <= '0;
    end else begin
      case (state)
        // Looking at count_nxt lets a push into an idle queue reach CHECK next cycle.
        IDLE:  if (count_nxt != '0) state <= CHECK;
        CHECK: begin
          if (bh_is_safe) begin
            state <= ISSUE;
          end else begin
            state <= WAIT;
            dly   <= DW'(T_DELAY - 1);
            if (throttle_cnt != 16'hFFFF) throttle_cnt <= throttle_cnt + 16'd1;
          end
        end
        WAIT: begin
          if (dly == '0) state <= CHECK;
          else           dly   <= dly - 1'b1;
        end
        ISSUE: if (act_ready) state <= (count_nxt != '0) ? CHECK : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_act_throttle_queue.sv
// Directed scenarios plus random traffic, checked every cycle against a queue/timeline model.
module tb_act_throttle_queue;
  localparam int ROW_W = 16, CORE_W = 3, DEPTH = 4, T_DELAY = 32;

  logic clk = 1'b0;
  logic rst, req_valid, req_ready, bh_in_valid, bh_is_safe, act_valid, act_ready, busy;
  logic [ROW_W-1:0]  req_row, bh_row_addr, act_row;
  logic [CORE_W-1:0] req_core, bh_core_id, act_core;
  logic [15:0]       throttle_cnt;

  always #5 clk = ~clk;

  act_throttle_queue #(.ROW_W(ROW_W), .CORE_W(CORE_W), .DEPTH(DEPTH), .T_DELAY(T_DELAY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_row(req_row),
    .req_core(req_core), .bh_row_addr(bh_row_addr), .bh_core_id(bh_core_id),
    .bh_in_valid(bh_in_valid), .bh_is_safe(bh_is_safe), .act_valid(act_valid),
    .act_ready(act_ready), .act_row(act_row), .act_core(act_core), .busy(busy),
    .throttle_cnt(throttle_cnt));

  typedef struct {logic [ROW_W-1:0] row; logic [CORE_W-1:0] core;} ent_t;

  // Model: pending requests, whether the head is being offered, and the cycle of the next verdict.
  ent_t    q[$];
  bit      issuing;
  longint  check_at;
  int      thr;
  longint  cyc;
  int      unsafe_left;
  bit      rand_mode;

  int n_chk, n_err;
  int bhv_pulses, av_cnt;
  longint first_av, t0;
  logic [ROW_W-1:0] obs_rows[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete(); issuing = 0; check_at = -1; thr = 0;
  endtask

  task automatic step();
    bit nonempty, idle, push, pop;
    if (!rand_mode) bh_is_safe = (unsafe_left == 0);
    @(negedge clk);
    nonempty = (q.size() > 0);
    if (rst) begin
      chk("rst_act_valid", 32'(act_valid), 0);
      chk("rst_bh_in_valid", 32'(bh_in_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_req_ready", 32'(req_ready), 1);
      chk("rst_act_row", 32'(act_row), 0);
      chk("rst_act_core", 32'(act_core), 0);
      chk("rst_bh_row", 32'(bh_row_addr), 0);
      chk("rst_bh_core", 32'(bh_core_id), 0);
      chk("rst_throttle", 32'(throttle_cnt), 0);
      model_reset();
    end else begin
      chk("act_valid", 32'(act_valid), 32'(issuing));
      chk("bh_in_valid", 32'(bh_in_valid), 32'(issuing && act_ready));
      chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
      chk("busy", 32'(busy), 32'(nonempty || issuing || check_at >= 0));
      chk("act_row", 32'(act_row), nonempty ? 32'(q[0].row) : 0);
      chk("act_core", 32'(act_core), nonempty ? 32'(q[0].core) : 0);
      chk("bh_row", 32'(bh_row_addr), nonempty ? 32'(q[0].row) : 0);
      chk("bh_core", 32'(bh_core_id), nonempty ? 32'(q[0].core) : 0);
      chk("throttle", 32'(throttle_cnt), 32'(thr));
      if (act_valid && first_av < 0) first_av = cyc;
      if (act_valid) av_cnt++;
      if (bh_in_valid) begin bhv_pulses++; obs_rows.push_back(act_row); end

      idle = !issuing && check_at < 0;
      push = req_valid && (q.size() < DEPTH);
      pop  = issuing && act_ready;
      if (check_at == cyc) begin
        if (bh_is_safe) begin
          issuing = 1; check_at = -1;
        end else begin
          if (thr < 16'hFFFF) thr++;
          check_at = cyc + T_DELAY + 1;
          if (unsafe_left > 0) unsafe_left--;
        end
      end
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{row: req_row, core: req_core});
      if (pop) begin
        issuing = 0;
        if (q.size() > 0) check_at = cyc + 1;
      end
      if (idle && push) check_at = cyc + 1;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic push_req(input logic [ROW_W-1:0] row, input logic [CORE_W-1:0] core);
    req_valid = 1; req_row = row; req_core = core;
    step();
    req_valid = 0;
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; rand_mode = 0; unsafe_left = 0;
    rst = 1; req_valid = 0; req_row = '0; req_core = '0; act_ready = 1; bh_is_safe = 1;
    model_reset();
    #1;
    repeat (3) step();
    rst = 0;

    // Single safe request: two-cycle latency, then idle.
    t0 = cyc; first_av = -1;
    push_req(16'h1234, 3'd2);
    repeat (5) step();
    chk("s1_latency", 32'(first_av - t0), 2);
    chk("s1_throttle", 32'(throttle_cnt), 0);
    chk("s1_idle", 32'(busy), 0);

    // One unsafe verdict adds T_DELAY+1 cycles.
    unsafe_left = 1; t0 = cyc; first_av = -1;
    push_req(16'h1234, 3'd2);
    repeat (40) step();
    chk("s2_latency", 32'(first_av - t0), 35);
    chk("s2_throttle", 32'(throttle_cnt), 1);

    // Backpressure in ISSUE: held, no insert until the handshake.
    act_ready = 0; bhv_pulses = 0;
    push_req(16'h0ABC, 3'd5);
    repeat (12) step();
    chk("s3_no_pulse", 32'(bhv_pulses), 0);
    chk("s3_held", 32'(act_valid), 1);
    act_ready = 1;
    repeat (4) step();
    chk("s3_one_pulse", 32'(bhv_pulses), 1);

    // Fill to DEPTH, fifth request refused, drain in order.
    act_ready = 0; bhv_pulses = 0; obs_rows.delete();
    for (int i = 1; i <= 4; i++) push_req(16'(i), 3'(i));
    chk("s4_full", 32'(req_ready), 0);
    push_req(16'd5, 3'd5);
    act_ready = 1;
    repeat (30) step();
    chk("s4_pulses", 32'(bhv_pulses), 4);
    chk("s4_drained", 32'(obs_rows.size()), 4);
    for (int i = 0; i < 4 && i < obs_rows.size(); i++) chk("s4_order", 32'(obs_rows[i]), 32'(i + 1));

    // Head-of-line blocking behind an unsafe head.
    unsafe_left = 1; obs_rows.delete();
    push_req(16'h000A, 3'd1);
    push_req(16'h000B, 3'd2);
    repeat (45) step();
    chk("s5_count", 32'(obs_rows.size()), 2);
    if (obs_rows.size() == 2) begin
      chk("s5_first", 32'(obs_rows[0]), 32'h000A);
      chk("s5_second", 32'(obs_rows[1]), 32'h000B);
    end

    // Reset during WAIT with three entries pending discards them.
    unsafe_left = 1;
    push_req(16'h0031, 3'd1);
    push_req(16'h0032, 3'd2);
    push_req(16'h0033, 3'd3);
    repeat (8) step();
    rst = 1;
    step();
    rst = 0; unsafe_left = 0; av_cnt = 0; bhv_pulses = 0;
    repeat (60) step();
    chk("s6_no_act", 32'(av_cnt), 0);
    chk("s6_no_insert", 32'(bhv_pulses), 0);

    // Random traffic with occasional resets.
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 599) == 0);
      req_valid  = $urandom_range(0, 2) == 0;
      req_row    = 16'($urandom);
      req_core   = 3'($urandom);
      act_ready  = $urandom_range(0, 3) != 0;
      bh_is_safe = $urandom_range(0, 2) != 0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
